// File: rtl/apb_timer_slave_pkg.sv
// apb_timer_slave_pkg: register map and bit positions shared by APB timer slaves and their benches
package apb_timer_slave_pkg;
   typedef enum logic [2:0] {
      REG_CTRL     = 3'd0,
      REG_LOAD     = 3'd1,
      REG_VALUE    = 3'd2,
      REG_PRESCALE = 3'd3,
      REG_STATUS   = 3'd4
   } reg_e;
   localparam int CTRL_EN        = 0;
   localparam int CTRL_IRQ_EN    = 1;
   localparam int CTRL_RELOAD    = 2;
   localparam int STATUS_EXPIRED = 0;
endpackage

// File: rtl/apb_timer_prescaler.sv
// apb_timer_prescaler: divides clk by prescale+1, emitting a one-cycle tick
module apb_timer_prescaler #(
   parameter int PRE_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [PRE_W-1:0] prescale,
   output logic             tick
);
   logic [PRE_W-1:0] pcnt;
   assign tick = en & (pcnt == prescale);
   // count while enabled; disable, restart or terminal count return to 0
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pcnt <= '0;
      else pcnt <= (!en || clr || tick) ? '0 : pcnt + PRE_W'(1);
endmodule

// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB down-counting timer with prescaler, one-shot/reload modes and expiry interrupt
module apb_timer_slave
   import apb_timer_slave_pkg::*;
#(
   parameter int SEL_IDX = 0,
   parameter int CNT_W   = 32,
   parameter int PRE_W   = 16
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic [2:0]  pselx,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        irq
);
   logic             en, irq_en, reload, expired, tick;
   logic [CNT_W-1:0] load, value;
   logic [PRE_W-1:0] prescale;
   logic [2:0]       idx;
   logic             sel, wr, wr_ctrl, wr_load, wr_pre, wr_stat, expire, clr;
   logic             unused;
   assign sel     = pselx[SEL_IDX];
   assign idx     = paddr[4:2];
   assign wr      = sel & penable & pwrite;
   assign wr_ctrl = wr & (idx == REG_CTRL);
   assign wr_load = wr & (idx == REG_LOAD);
   assign wr_pre  = wr & (idx == REG_PRESCALE);
   assign wr_stat = wr & (idx == REG_STATUS);
   assign expire  = tick & (value == '0);
   assign clr     = wr_load | (wr_ctrl & pwdata[CTRL_EN] & ~en);
   assign irq     = expired & irq_en;
   assign unused  = ^{pselx, paddr, pwdata};

   apb_timer_prescaler #(.PRE_W(PRE_W)) u_pre (
      .clk(hclk),
      .rst_n(hresetn),
      .en(en),
      .clr(clr),
      .prescale(prescale),
      .tick(tick)
   );

   // register bank and down-counter; bus writes take priority over counter events except expiry set
   always_ff @(posedge hclk or negedge hresetn)
      if (!hresetn) begin
         en       <= 1'b0;
         irq_en   <= 1'b0;
         reload   <= 1'b0;
         load     <= '0;
         value    <= '0;
         prescale <= '0;
         expired  <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en     <= pwdata[CTRL_EN];
            irq_en <= pwdata[CTRL_IRQ_EN];
            reload <= pwdata[CTRL_RELOAD];
         end else if (expire && !reload) en <= 1'b0;
         if (wr_load) begin
            load  <= pwdata[CNT_W-1:0];
            value <= pwdata[CNT_W-1:0];
         end else if (tick) value <= (value != '0) ? value - CNT_W'(1) : (reload ? load : value);
         if (wr_pre) prescale <= pwdata[PRE_W-1:0];
         if (expire) expired <= 1'b1;
         else if (wr_stat && pwdata[STATUS_EXPIRED]) expired <= 1'b0;
      end

   // read mux, driven only while this slave is selected
   always_comb begin
      prdata = '0;
      if (sel)
         prdata = (idx == REG_CTRL)     ? 32'({reload, irq_en, en}) :
                  (idx == REG_LOAD)     ? 32'(load) :
                  (idx == REG_VALUE)    ? 32'(value) :
                  (idx == REG_PRESCALE) ? 32'(prescale) :
                  (idx == REG_STATUS)   ? 32'(expired) : 32'd0;
   end
endmodule

// File: tb/tb_apb_timer_slave.sv
// tb_apb_timer_slave: directed bench for apb_timer_slave (default instance plus narrow instance on pselx[1])
module tb_apb_timer_slave;
   import apb_timer_slave_pkg::*;
   logic        hclk = 1'b0;
   logic        hresetn;
   logic [2:0]  pselx;
   logic        penable, pwrite;
   logic [31:0] paddr, pwdata, prdata0, prdata1;
   logic        irq0, irq1;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] pv;
   bit          found;
   int          exp_v [6] = '{2, 1, 0, 2, 1, 0};
   int          exp_s [6] = '{0, 0, 0, 1, 1, 1};

   always #5 hclk = ~hclk;

   apb_timer_slave #(.SEL_IDX(0)) dut0 (
      .hclk(hclk), .hresetn(hresetn), .pselx(pselx), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .irq(irq0)
   );

   apb_timer_slave #(.SEL_IDX(1), .CNT_W(8), .PRE_W(4)) dut1 (
      .hclk(hclk), .hresetn(hresetn), .pselx(pselx), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .irq(irq1)
   );

   function automatic logic [31:0] a(input reg_e r);
      return {27'd0, r, 2'b00};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic peek(input logic [2:0] sel, input logic [31:0] addr, input bit d1, output logic [31:0] d);
      pselx = sel; paddr = addr; pwrite = 1'b0; penable = 1'b0;
      #1;
      d = d1 ? prdata1 : prdata0;
      pselx = 3'b000;
   endtask

   task automatic chk_rd(input string tag, input logic [2:0] sel, input logic [31:0] addr, input bit d1,
                         input logic [31:0] exp);
      logic [31:0] d;
      peek(sel, addr, d1, d);
      chk(tag, d, exp);
   endtask

   // commits on the second rising edge after the call when called just after an edge
   task automatic wr(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] data);
      @(negedge hclk);
      pselx = sel; paddr = addr; pwdata = data; pwrite = 1'b1; penable = 1'b0;
      @(negedge hclk);
      penable = 1'b1;
      @(posedge hclk);
      #1;
      pselx = 3'b000; penable = 1'b0; pwrite = 1'b0;
   endtask

   initial begin
      hresetn = 1'b0; pselx = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      #2;
      chk("rst_prdata", prdata0, 32'd0);
      chk("rst_irq", {31'd0, irq0}, 32'd0);
      for (int i = 0; i < 5; i++) chk_rd($sformatf("rst_reg%0d", i), 3'b001, 32'(i * 4), 0, 32'd0);
      repeat (2) @(negedge hclk);
      hresetn = 1'b1;
      @(posedge hclk); #1;
      // one-shot: PRESCALE=1, LOAD=3 -> expiry 8 clk after CTRL commit
      wr(3'b001, a(REG_PRESCALE), 32'd1);
      wr(3'b001, a(REG_LOAD), 32'd3);
      wr(3'b001, a(REG_CTRL), 32'h3);
      repeat (7) @(posedge hclk); #1;
      chk("os_irq_early", {31'd0, irq0}, 32'd0);
      chk_rd("os_stat_early", 3'b001, a(REG_STATUS), 0, 32'd0);
      chk_rd("os_value_zero", 3'b001, a(REG_VALUE), 0, 32'd0);
      @(posedge hclk); #1;
      chk("os_irq", {31'd0, irq0}, 32'd1);
      chk_rd("os_stat", 3'b001, a(REG_STATUS), 0, 32'd1);
      chk_rd("os_ctrl_en_off", 3'b001, a(REG_CTRL), 0, 32'h2);
      wr(3'b001, a(REG_STATUS), 32'd1);
      chk("w1c_irq", {31'd0, irq0}, 32'd0);
      chk_rd("w1c_stat", 3'b001, a(REG_STATUS), 0, 32'd0);
      // auto-reload: PRESCALE=0, LOAD=2, IRQ_EN=0
      wr(3'b001, a(REG_PRESCALE), 32'd0);
      wr(3'b001, a(REG_LOAD), 32'd2);
      wr(3'b001, a(REG_CTRL), 32'h5);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            @(posedge hclk); #1;
         end
         chk_rd($sformatf("ar_value%0d", i), 3'b001, a(REG_VALUE), 0, 32'(exp_v[i]));
         chk_rd($sformatf("ar_stat%0d", i), 3'b001, a(REG_STATUS), 0, 32'(exp_s[i]));
         chk($sformatf("ar_irq_masked%0d", i), {31'd0, irq0}, 32'd0);
      end
      // W1C landing on the expiry edge: set wins
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         @(posedge hclk); #1;
         peek(3'b001, a(REG_VALUE), 0, pv);
         found = (pv == 32'd1);
      end
      chk("poll_value1", {31'd0, found}, 32'd1);
      wr(3'b001, a(REG_STATUS), 32'd1);
      chk_rd("col_w1c_stat", 3'b001, a(REG_STATUS), 0, 32'd1);
      chk_rd("col_w1c_value", 3'b001, a(REG_VALUE), 0, 32'd2);
      wr(3'b001, a(REG_STATUS), 32'd1);
      chk_rd("w1c_noclash", 3'b001, a(REG_STATUS), 0, 32'd0);
      // LOAD write on a tick clk: write wins
      wr(3'b001, a(REG_LOAD), 32'd9);
      chk_rd("col_load_value", 3'b001, a(REG_VALUE), 0, 32'd9);
      chk_rd("col_load_load", 3'b001, a(REG_LOAD), 0, 32'd9);
      // stop: the EN=0 commit edge still carries one tick (9->8->7)
      wr(3'b001, a(REG_CTRL), 32'h0);
      chk_rd("stop_ctrl", 3'b001, a(REG_CTRL), 0, 32'h0);
      chk_rd("stop_value", 3'b001, a(REG_VALUE), 0, 32'd7);
      repeat (3) @(posedge hclk); #1;
      chk_rd("stop_frozen", 3'b001, a(REG_VALUE), 0, 32'd7);
      // decode: other pselx line, width truncation on narrow instance
      wr(3'b010, a(REG_LOAD), 32'hFFFF_FF05);
      chk_rd("dec_other_sel", 3'b001, a(REG_LOAD), 0, 32'd9);
      chk_rd("dec_prdata_unsel", 3'b010, a(REG_LOAD), 0, 32'd0);
      chk_rd("w8_load", 3'b010, a(REG_LOAD), 1, 32'h05);
      chk_rd("w8_value", 3'b010, a(REG_VALUE), 1, 32'h05);
      wr(3'b010, a(REG_PRESCALE), 32'hFFFF_FFFF);
      chk_rd("w4_prescale", 3'b010, a(REG_PRESCALE), 1, 32'h0F);
      wr(3'b001, 32'h18, 32'hFFFF_FFFF);
      chk_rd("unmapped_rd", 3'b001, 32'h18, 0, 32'd0);
      chk_rd("unmapped_wr_load", 3'b001, a(REG_LOAD), 0, 32'd9);
      chk_rd("unmapped_wr_ctrl", 3'b001, a(REG_CTRL), 0, 32'd0);
      chk_rd("unmapped_wr_pre", 3'b001, a(REG_PRESCALE), 0, 32'd0);
      @(negedge hclk);
      pselx = 3'b001; paddr = a(REG_LOAD); pwdata = 32'h77; pwrite = 1'b1; penable = 1'b0;
      @(posedge hclk); #1;
      pselx = 3'b000; pwrite = 1'b0;
      chk_rd("setup_only_wr", 3'b001, a(REG_LOAD), 0, 32'd9);
      wr(3'b001, 32'hABCD_0027, 32'h11);
      chk_rd("addr_alias_load", 3'b001, a(REG_LOAD), 0, 32'h11);
      chk_rd("addr_alias_value", 3'b001, a(REG_VALUE), 0, 32'h11);
      // reset mid-count
      wr(3'b001, a(REG_LOAD), 32'd100);
      wr(3'b001, a(REG_CTRL), 32'h1);
      repeat (3) @(posedge hclk); #1;
      chk_rd("mid_value", 3'b001, a(REG_VALUE), 0, 32'd97);
      #2 hresetn = 1'b0;
      #1;
      chk_rd("arst_value", 3'b001, a(REG_VALUE), 0, 32'd0);
      chk_rd("arst_ctrl", 3'b001, a(REG_CTRL), 0, 32'd0);
      chk_rd("arst_load", 3'b001, a(REG_LOAD), 0, 32'd0);
      chk("arst_irq", {31'd0, irq0}, 32'd0);
      @(negedge hclk);
      hresetn = 1'b1;
      repeat (3) @(posedge hclk); #1;
      chk_rd("post_rst_value", 3'b001, a(REG_VALUE), 0, 32'd0);
      wr(3'b001, a(REG_LOAD), 32'd5);
      repeat (4) @(posedge hclk); #1;
      chk_rd("post_rst_frozen", 3'b001, a(REG_VALUE), 0, 32'd5);
      chk("w8_irq", {31'd0, irq1}, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
